// File: rtl/file_register_master.sv
// Bus-side initiator for the 32x32 file_register: one read or write per request,
// with the shared data_bus driven only during a non-suppressed write.
module file_register_master #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [4:0]       req_addr,
   input  logic [31:0]      req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_write,
   output logic [31:0]      rsp_rdata,
   output logic             we,
   output logic [4:0]       read0_addr,
   output logic [4:0]       read1_addr,
   output logic [4:0]       write_addr,
   inout  wire  [31:0]      data_bus,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] rd_count
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t             state_q, state_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [4:0]         wr_addr_q, wr_addr_d;
   logic [4:0]         rd_addr_q, rd_addr_d;
   logic               rsp_write_q, rsp_write_d;
   logic [31:0]        rsp_rdata_q, rsp_rdata_d;
   logic [CNT_W-1:0]   wr_count_q, wr_count_d;
   logic [CNT_W-1:0]   rd_count_q, rd_count_d;
   logic               accept;
   logic               wr_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wdata_q     <= '0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         wr_count_q  <= '0;
         rd_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         wdata_q     <= wdata_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         wr_count_q  <= wr_count_d;
         rd_count_q  <= rd_count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (req_valid) state_d = req_write ? WRITE : READ;
         WRITE, READ: state_d = RESP;
         RESP:        if (rsp_ready) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   assign accept = (state_q == IDLE) && req_valid;

   // Each address register only moves when its own operation starts, so the
   // register file sees stable addresses between operations.
   always_comb begin
      wdata_d     = wdata_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      wr_count_d  = wr_count_q;
      rd_count_d  = rd_count_q;
      if (accept) begin
         wdata_d = req_wdata;
         if (req_write) wr_addr_d = req_addr;
         else           rd_addr_d = req_addr;
      end
      if (state_q == WRITE) begin
         rsp_write_d = 1'b1;
         rsp_rdata_d = '0;
         if (wr_en) wr_count_d = wr_count_q + CNT_W'(1);
      end
      if (state_q == READ) begin
         rsp_write_d = 1'b0;
         rsp_rdata_d = data_bus;
         rd_count_d  = rd_count_q + CNT_W'(1);
      end
   end

   // r0 is hardwired in the register file, so a write to it never asserts we.
   always_comb begin
      wr_en     = (state_q == WRITE) && (wr_addr_q != 5'd0);
      we        = wr_en;
      req_ready = (state_q == IDLE) && !rst;
      rsp_valid = (state_q == RESP);
   end

   assign data_bus   = we ? wdata_q : {32{1'bz}};
   assign rsp_write  = rsp_write_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign read0_addr = rd_addr_q;
   assign read1_addr = rd_addr_q;
   assign write_addr = wr_addr_q;
   assign wr_count   = wr_count_q;
   assign rd_count   = rd_count_q;

endmodule
